// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl
// Sits between a UART word loader and the CPU's instruction memory. While
// load_en is high, it turns each rising edge of the loader's word-ready level
// into one instruction-memory write. It also keeps a word count, a checksum
// and an out-of-range flag. When load_en drops, it holds the CPU in reset for
// RST_HOLD cycles and then releases it.
//
// Parameters
//   ADDR_W   : instruction-memory word-address width (depth = 2**ADDR_W)
//   RST_HOLD : cycles the CPU stays in reset after loading ends
//
// Ports
//   clk, rst_n  : system clock, asynchronous active-low reset
//   load_en     : loader-mode switch
//   ld_wr       : loader word-ready level (may stay high for many cycles)
//   ld_addr     : loader word address (all-ones = no word received yet)
//   ld_data     : loader assembled word
//   imem_we     : instruction-memory write strobe
//   imem_addr   : instruction-memory word address
//   imem_wdata  : instruction-memory write data
//   cpu_rst_n   : CPU reset, active-low
//   word_cnt    : accepted-word count, saturating at the memory depth
//   checksum    : sum modulo 2**32 of accepted words
//   overflow    : sticky flag, an out-of-range word was dropped
//   busy        : high whenever the controller is not in RUN
module boot_loader_ctrl #(
  parameter int ADDR_W   = 6,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              ld_wr,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic [ADDR_W:0]   word_cnt,
  output logic [31:0]       checksum,
  output logic              overflow,
  output logic              busy
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic                cpu_rst_n_r;
  logic                busy_r;
  logic                ld_wr_q_r;
  logic                pend_r;
  logic [ADDR_W-1:0]   pend_addr_r;
  logic [31:0]         pend_data_r;
  logic                imem_we_r;
  logic [ADDR_W-1:0]   imem_addr_r;
  logic [31:0]         imem_wdata_r;
  logic [ADDR_W:0]     word_cnt_r;
  logic [31:0]         checksum_r;
  logic                overflow_r;
  logic                load_entry_s;
  logic                wr_evt_s;
  logic                accept_s;
  logic                drop_s;

  // Next-state decode. In RELEASE, load_en wins over the hold counter.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (load_en) state_nxt_s = ST_LOAD;
        else         state_nxt_s = ST_RUN;
      end
      ST_LOAD: begin
        if (!load_en) state_nxt_s = ST_RELEASE;
        else          state_nxt_s = ST_LOAD;
      end
      ST_RELEASE: begin
        if (load_en)                       state_nxt_s = ST_LOAD;
        else if (hold_cnt_r == HOLD_LAST)  state_nxt_s = ST_RUN;
        else                               state_nxt_s = ST_RELEASE;
      end
      default: state_nxt_s = ST_RELEASE;
    endcase
  end

  // Classify the write event. Edge detect is on the registered ld_wr, and only the current LOAD state counts.
  always_comb begin
    load_entry_s = 1'b0;
    wr_evt_s     = 1'b0;
    accept_s     = 1'b0;
    drop_s       = 1'b0;
    if ((state_nxt_s == ST_LOAD) && (state_r != ST_LOAD)) load_entry_s = 1'b1;
    else                                                  load_entry_s = 1'b0;
    if (ld_wr && !ld_wr_q_r && (state_r == ST_LOAD)) wr_evt_s = 1'b1;
    else                                             wr_evt_s = 1'b0;
    // All-ones means "nothing received yet". Check it before the range test, because it is also out of range.
    if (!wr_evt_s || (&ld_addr)) begin
      accept_s = 1'b0;
      drop_s   = 1'b0;
    end else if (|ld_addr[31:ADDR_W]) begin
      accept_s = 1'b0;
      drop_s   = 1'b1;
    end else begin
      accept_s = 1'b1;
      drop_s   = 1'b0;
    end
  end

  // State register, hold counter and registered CPU reset / busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_RELEASE;
      hold_cnt_r  <= {HOLD_W{1'b0}};
      cpu_rst_n_r <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      // The hold counter restarts from zero on every entry to RELEASE.
      if (state_r == ST_RELEASE) hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
      else                       hold_cnt_r <= {HOLD_W{1'b0}};
      cpu_rst_n_r <= (state_nxt_s == ST_RUN);
      busy_r      <= (state_nxt_s != ST_RUN);
    end
  end

  // Word-ready history, sampled in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ld_wr_q_r <= 1'b0;
    else        ld_wr_q_r <= ld_wr;
  end

  // Capture stage: hold an accepted word for one cycle before the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r      <= 1'b0;
      pend_addr_r <= {ADDR_W{1'b0}};
      pend_data_r <= 32'd0;
    end else begin
      pend_r <= accept_s;
      if (accept_s) begin
        pend_addr_r <= ld_addr[ADDR_W-1:0];
        pend_data_r <= ld_data;
      end
    end
  end

  // Memory write port. Address and data hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we_r    <= 1'b0;
      imem_addr_r  <= {ADDR_W{1'b0}};
      imem_wdata_r <= 32'd0;
    end else begin
      imem_we_r <= pend_r;
      if (pend_r) begin
        imem_addr_r  <= pend_addr_r;
        imem_wdata_r <= pend_data_r;
      end
    end
  end

  // Load statistics. Clearing on LOAD entry takes precedence over a strobe completing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_r <= {(ADDR_W+1){1'b0}};
      checksum_r <= 32'd0;
      overflow_r <= 1'b0;
    end else if (load_entry_s) begin
      word_cnt_r <= {(ADDR_W+1){1'b0}};
      checksum_r <= 32'd0;
      overflow_r <= 1'b0;
    end else begin
      if (pend_r) begin
        checksum_r <= checksum_r + pend_data_r;
        if (word_cnt_r != DEPTH) word_cnt_r <= word_cnt_r + (ADDR_W+1)'(1);
      end
      if (drop_s) overflow_r <= 1'b1;
    end
  end

  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_rst_n  = cpu_rst_n_r;
  assign word_cnt   = word_cnt_r;
  assign checksum   = checksum_r;
  assign overflow   = overflow_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl. A behavioural model tracks the
// expected outputs every clock and is compared on each falling edge. Directed
// scenarios pin the model to hand-computed values. A randomized phase follows.
module tb_boot_loader_ctrl;

  localparam int ADDR_W   = 6;
  localparam int RST_HOLD = 4;
  localparam int DEPTH    = 64;
  localparam int M_LOAD = 0, M_REL = 1, M_RUN = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_en;
  logic              ld_wr;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic [ADDR_W:0]   word_cnt;
  logic [31:0]       checksum;
  logic              overflow;
  logic              busy;

  int total = 0;
  int bad   = 0;
  int we_count = 0;
  bit cmp_en = 1'b0;

  boot_loader_ctrl #(.ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .ld_wr(ld_wr),
    .ld_addr(ld_addr), .ld_data(ld_data), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n),
    .word_cnt(word_cnt), .checksum(checksum), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode;
  int          m_rel_cycles;
  bit          m_prev_wr;
  bit          m_pend;
  logic [31:0] m_pend_a, m_pend_d;
  bit          m_we;
  logic [31:0] m_addr, m_data, m_sum;
  int          m_cnt;
  bit          m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_REL; m_rel_cycles = 0; m_prev_wr = 0; m_pend = 0;
      m_pend_a = 0; m_pend_d = 0;
      m_we = 0; m_addr = 0; m_data = 0; m_sum = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      int  old_mode;
      bit  evt;
      old_mode = m_mode;
      evt = ld_wr && !m_prev_wr && (old_mode == M_LOAD);
      // a word accepted on the previous edge is written now
      m_we = m_pend;
      if (m_pend) begin
        m_addr = m_pend_a;
        m_data = m_pend_d;
        m_sum  = m_sum + m_pend_d;
        if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
      end
      // mode transitions
      if (old_mode == M_RUN) begin
        if (load_en) m_mode = M_LOAD;
      end else if (old_mode == M_LOAD) begin
        if (!load_en) begin m_mode = M_REL; m_rel_cycles = 0; end
      end else begin
        if (load_en) m_mode = M_LOAD;
        else begin
          m_rel_cycles++;
          if (m_rel_cycles == RST_HOLD) m_mode = M_RUN;
        end
      end
      if (m_mode == M_LOAD && old_mode != M_LOAD) begin
        m_cnt = 0; m_sum = 0; m_ovf = 0;
      end
      m_pend = 0;
      if (evt && ld_addr != 32'hFFFF_FFFF) begin
        if (ld_addr >= DEPTH) m_ovf = 1;
        else begin
          m_pend = 1; m_pend_a = ld_addr; m_pend_d = ld_data;
        end
      end
      m_prev_wr = ld_wr;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    we_count += int'(imem_we);
    if (cmp_en) begin
      chk("imem_we",    32'(imem_we),    32'(m_we));
      chk("imem_addr",  32'(imem_addr),  m_addr);
      chk("imem_wdata", imem_wdata,      m_data);
      chk("cpu_rst_n",  32'(cpu_rst_n),  32'(m_mode == M_RUN));
      chk("busy",       32'(busy),       32'(m_mode != M_RUN));
      chk("word_cnt",   32'(word_cnt),   32'(m_cnt));
      chk("checksum",   checksum,        m_sum);
      chk("overflow",   32'(overflow),   32'(m_ovf));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_wr(input logic [31:0] a, input logic [31:0] d);
    ld_addr = a; ld_data = d; ld_wr = 1'b1;
    cyc(3);
    ld_wr = 1'b0;
    cyc(2);
  endtask

  initial begin
    int first;
    int w0;
    rst_n = 1'b0; load_en = 1'b0; ld_wr = 1'b0;
    ld_addr = 32'hFFFF_FFFF; ld_data = 32'd0;
    cyc(2);
    cmp_en = 1'b1;
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_busy",      32'(busy),      32'd1);
    chk("rst_imem_we",   32'(imem_we),   32'd0);
    chk("rst_word_cnt",  32'(word_cnt),  32'd0);

    // reset release with load_en low: CPU out of reset after RST_HOLD cycles
    rst_n = 1'b1;
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (cpu_rst_n && first == 0) first = i;
    end
    chk("rise_cycles", 32'(first), 32'd4);
    chk("run_busy",    32'(busy),  32'd0);
    chk("no_strobes",  32'(we_count), 32'd0);

    // one word, ld_wr held high for 50 cycles
    load_en = 1'b1;
    cyc(2);
    w0 = we_count;
    ld_addr = 32'd0; ld_data = 32'h0000_0013; ld_wr = 1'b1;
    cyc(50);
    ld_wr = 1'b0;
    cyc(2);
    chk("hold_strobes", 32'(we_count - w0), 32'd1);
    chk("hold_addr",    32'(imem_addr),     32'd0);
    chk("hold_data",    imem_wdata,         32'h0000_0013);
    chk("hold_cnt",     32'(word_cnt),      32'd1);
    chk("hold_sum",     checksum,           32'h0000_0013);

    // re-enter LOAD, then an "empty" address and an out-of-range address
    load_en = 1'b0; cyc(1);
    load_en = 1'b1; cyc(1);
    chk("reentry_cnt", 32'(word_cnt), 32'd0);
    w0 = we_count;
    pulse_wr(32'hFFFF_FFFF, 32'h1234_5678);
    pulse_wr(32'd64, 32'h8765_4321);
    chk("drop_strobes", 32'(we_count - w0), 32'd0);
    chk("drop_cnt",     32'(word_cnt),      32'd0);
    chk("drop_ovf",     32'(overflow),      32'd1);

    // checksum wraps modulo 2^32
    load_en = 1'b0; cyc(1);
    load_en = 1'b1; cyc(1);
    chk("clear_ovf", 32'(overflow), 32'd0);
    pulse_wr(32'd0, 32'hFFFF_FFFF);
    pulse_wr(32'd1, 32'h0000_0002);
    chk("wrap_sum", checksum,         32'h0000_0001);
    chk("wrap_cnt", 32'(word_cnt),    32'd2);

    // load_en falls on the same edge as ld_wr rises
    w0 = we_count;
    ld_addr = 32'd5; ld_data = 32'hA5A5_A5A5; ld_wr = 1'b1; load_en = 1'b0;
    @(negedge clk);
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (cpu_rst_n && first == 0) first = i;
    end
    ld_wr = 1'b0;
    chk("late_strobes", 32'(we_count - w0), 32'd1);
    chk("late_addr",    32'(imem_addr),     32'd5);
    chk("late_data",    imem_wdata,         32'hA5A5_A5A5);
    chk("late_cnt",     32'(word_cnt),      32'd3);
    chk("late_sum",     checksum,           32'hA5A5_A5A6);
    chk("late_rise",    32'(first),         32'd4);

    // load_en back high in RELEASE after two hold cycles
    load_en = 1'b1; cyc(2);
    pulse_wr(32'd2, 32'h0000_0007);
    load_en = 1'b0;
    @(negedge clk);
    cyc(2);
    load_en = 1'b1;
    @(negedge clk);
    cyc(1);
    chk("abort_cnt", 32'(word_cnt),  32'd0);
    chk("abort_sum", checksum,       32'd0);
    chk("abort_cpu", 32'(cpu_rst_n), 32'd0);
    chk("abort_busy", 32'(busy),     32'd1);

    // randomized traffic, including occasional mid-run resets
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 24) == 0) load_en = ~load_en;
      if ($urandom_range(0, 3) == 0) ld_wr = ~ld_wr;
      case ($urandom_range(0, 7))
        0, 1, 2, 3: ld_addr = 32'($urandom_range(0, 63));
        4:          ld_addr = 32'hFFFF_FFFF;
        5:          ld_addr = 32'(64 + $urandom_range(0, 200));
        6:          ld_addr = $urandom;
        default:    ld_addr = 32'd63;
      endcase
      ld_data = $urandom;
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        cyc(2);
        #2 rst_n = 1'b1;
      end
    end
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boot_loader_ctrl.md
BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter ADDR_W SHALL default to 6 and set the instruction-memory word-address width, giving a depth of 2^ADDR_W words.
REQ-003 Parameter RST_HOLD SHALL default to 4 and set the number of cycles the CPU stays in reset after loading ends.
REQ-004 Port clk SHALL be a 1-bit input: the system clock.
REQ-005 Port rst_n SHALL be a 1-bit input: asynchronous active-low reset.
REQ-006 Port load_en SHALL be a 1-bit input: the loader-mode switch, shared with the upstream UART word loader's enable.
REQ-007 Port ld_wr SHALL be a 1-bit input: the loader's word-ready level, which may stay high for many cycles.
REQ-008 Port ld_addr SHALL be a 32-bit input: the loader's word address, where all-ones means no word received yet.
REQ-009 Port ld_data SHALL be a 32-bit input: the loader's assembled word.
REQ-010 Port imem_we SHALL be a 1-bit output: the instruction-memory write strobe.
REQ-011 Port imem_addr SHALL be an ADDR_W-bit output: the instruction-memory word address.
REQ-012 Port imem_wdata SHALL be a 32-bit output: the instruction-memory write data.
REQ-013 Port cpu_rst_n SHALL be a 1-bit output: the CPU reset, active-low.
REQ-014 Port word_cnt SHALL be an (ADDR_W+1)-bit output: the count of accepted words.
REQ-015 Port checksum SHALL be a 32-bit output: the sum modulo 2^32 of accepted words.
REQ-016 Port overflow SHALL be a 1-bit output: set when a word addressed at or beyond the memory depth is dropped.
REQ-017 Port busy SHALL be a 1-bit output: high whenever the state is not RUN.

Function
REQ-018 The FSM SHALL have three states: LOAD, RELEASE and RUN.
REQ-019 The FSM SHALL move from RUN to LOAD when load_en=1 is sampled.
REQ-020 The FSM SHALL move from LOAD to RELEASE when load_en=0 is sampled.
REQ-021 In RELEASE, a hold counter SHALL count RST_HOLD cycles and then the FSM SHALL move to RUN.
REQ-022 In RELEASE, load_en=1 SHALL take priority over the hold counter and move the FSM to LOAD.
REQ-023 cpu_rst_n SHALL be registered, 0 in LOAD and RELEASE, and 1 only in RUN.
REQ-024 On every entry to LOAD, the block SHALL clear word_cnt, checksum and overflow in the same cycle as the state change.
REQ-025 ld_wr SHALL be registered every cycle into ld_wr_q, regardless of state.
REQ-026 A write event SHALL be ld_wr=1 with ld_wr_q=0, sampled while the state is LOAD.
REQ-027 A write event with ld_addr equal to all-ones SHALL be ignored, with no strobe and no counter update.
REQ-028 A write event with ld_addr >= 2^ADDR_W SHALL set overflow sticky-high, produce no strobe, and leave word_cnt and checksum unchanged.
REQ-029 Any other write event SHALL be accepted.
REQ-030 For an event sampled at edge N, imem_we SHALL be 1 for exactly the one cycle after edge N+1, with imem_addr = ld_addr[ADDR_W-1:0] and imem_wdata = ld_data as captured at edge N.
REQ-031 imem_addr and imem_wdata SHALL hold their last values while imem_we=0.
REQ-032 At edge N+1, checksum SHALL update to checksum + ld_data, wrapping modulo 2^32.
REQ-033 At edge N+1, word_cnt SHALL increment and saturate at 2^ADDR_W.
REQ-034 If load_en falls in the same cycle as a write event, the write SHALL still be accepted, because the state sampled is LOAD.
REQ-035 ld_wr edges SHALL be ignored in RELEASE and RUN.
REQ-036 A write event SHALL never produce more than one strobe, even if ld_wr stays high.

Reset
REQ-037 While rst_n=0, the block SHALL immediately force state=RELEASE, hold counter=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, word_cnt=0, checksum=0, overflow=0, ld_wr_q=0 and busy=1.
REQ-038 After rst_n deasserts with load_en=0, cpu_rst_n SHALL rise after RST_HOLD cycles.
REQ-039 Reset asserted mid-load SHALL abort any pending strobe and return the block to the REQ-037 values.

Verification
REQ-040 The bench SHALL apply rst_n low then high with load_en=0 -> cpu_rst_n rises exactly 4 cycles later, busy=0, imem_we never set.
REQ-041 The bench SHALL raise load_en and pulse ld_wr 0->1 with ld_addr=0 and ld_data=0x00000013, holding ld_wr high for 50 cycles -> one imem_we pulse, addr 0, data 0x00000013, word_cnt=1, checksum=0x00000013.
REQ-042 The bench SHALL drive ld_wr rising with ld_addr=0xFFFFFFFF, then rising with ld_addr=64 -> no strobes, word_cnt=0, overflow=1.
REQ-043 The bench SHALL write 0xFFFFFFFF then 0x00000002 to addresses 0 and 1 -> checksum=0x00000001, word_cnt=2.
REQ-044 The bench SHALL make load_en fall on the same edge as ld_wr rises (addr 5, data 0xA5A5A5A5) -> the write is accepted, then cpu_rst_n rises 4 cycles after RELEASE entry.
REQ-045 The bench SHALL re-raise load_en during RELEASE after 2 hold cycles -> back to LOAD, counters cleared, cpu_rst_n stays 0.
